lfsr_gen: RTL
=============

# lfsr_gen

Parametrised linear-feedback shift register generator, the general-width successor to the team's fixed 4-bit LFSR. It produces a pseudo-random state word and a serial bit and supports both Fibonacci and Galois update structures, a step enable, and runtime seed loading. A lockup guard blocks the all-zero state. Period-detection logic reports when the sequence returns to its start value and how many steps that took. It feeds PRBS pattern sources and scrambler test benches in the design.

## Interface
- WIDTH, 4, state width in bits; legal 2..32
- TAPS, 4'b1001, feedback mask [WIDTH-1:0]; default realises x^4+x^3+1 (maximal length, period 15 at WIDTH=4)
- SEED, 1, reset and fallback state [WIDTH-1:0]; must be nonzero
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  advance one step this cycle
- load  in  1  load seed_in this cycle; has priority over en
- seed_in  in  WIDTH  seed value for load
- mode  in  1  0 = Fibonacci, 1 = Galois; sampled on every step
- out  out  WIDTH  current LFSR state (registered)
- bit_out  out  1  serial output, equals out[WIDTH-1]
- wrap  out  1  one-cycle pulse: a step returned state to the start value
- period  out  WIDTH  step count of the last completed cycle; 0 until the first wrap
- lockup  out  1  one-cycle pulse: a zero seed load was replaced with SEED

## Operation
- Internal registers:
  - state (drives out)
  - start (the value the current run began from)
  - cnt [WIDTH-1:0] (steps taken since start)
- Step equations, with s = state:
  - Fibonacci: fb = ^(s & TAPS); next = {s[WIDTH-2:0], fb}
  - Galois: next = {s[WIDTH-2:0], 1'b0} ^ ({WIDTH{s[WIDTH-1]}} & TAPS)
- Per-cycle priority:
  - rst: state = SEED, start = SEED, cnt = 0, period = 0, wrap = 0, lockup = 0.
  - Else if load:
    - If seed_in != 0: state = seed_in and start = seed_in.
    - If seed_in == 0: state = SEED, start = SEED, lockup = 1 for one cycle.
    - In both cases cnt = 0, wrap = 0, and period is held.
  - Else if en:
    - state = next and cnt = cnt + 1.
    - If next == start: wrap = 1, period = cnt + 1, cnt = 0.
  - Else: all registers hold; wrap = 0, lockup = 0.
- The all-zero state is unreachable. Reset and load never produce it, and steps from a nonzero state cannot reach it.
- If mode changes mid-run, the new structure applies from the next step. start and cnt are not reset. Period detection still fires whenever next == start.
- cnt wraps modulo 2^WIDTH. A maximal sequence has period 2^WIDTH-1, so it never overflows on a maximal polynomial. A non-maximal TAPS value gives its true period.
- bit_out is combinational from state. There is no extra register stage.

## Timing
- Latency is one cycle. A step, load or reset sampled at edge N is visible on out after edge N.
- wrap is registered alongside state. It is high in exactly the cycle out shows the start value again, and period updates on that same edge.
- lockup is high for the single cycle after the zero-seed load edge.
- load and en high together perform the load only; no step is taken that cycle.
- rst and load high together: rst wins.
- A reset or load mid-run discards progress. cnt restarts from 0 and the next wrap is measured from the new start.
- en held low: out, cnt and period are frozen indefinitely. No spurious wrap is produced.
- Reset values: out = SEED, bit_out = SEED[WIDTH-1], wrap = 0, period = 0, lockup = 0.

## Test plan
- **Fibonacci sequence, defaults.** Release rst, mode = 0, en = 1. Required: out = 0x3, 0x7, 0xF, 0xE, 0xD, 0xA on the first six steps. On step 15, out = 0x1, wrap = 1 for one cycle, and period = 15.
- **Galois sequence.** Reset, mode = 1, en = 1. Required: out = 0x2, 0x4, 0x8, 0x9, 0xB. On step 15, out = 0x1 and wrap = 1. Then period = 15.
- **Seed load with simultaneous en.** load = 1 with seed_in = 0x6 and en = 1. Required: out = 0x6 with no step taken. After a further 15 steps, wrap = 1 with out = 0x6.
- **Zero seed.** load = 1 with seed_in = 0. Required: out = 0x1 and lockup = 1 for one cycle. out never equals 0 in the following 40 steps.
- **Enable gating.** en = 0 for 10 cycles mid-run. Required: out and period unchanged and wrap = 0 throughout. The sequence resumes exactly where it stopped.
- **Reset mid-run.** Assert rst after 7 steps with period = 15 latched. Required: out = 0x1 and period = 0 after the edge. The next wrap occurs exactly 15 steps later.

Source files
------------

// File: rtl/lfsr_gen.sv
// lfsr_gen -- parametrised LFSR pattern generator.
//
// Produces a pseudo-random state word plus a serial bit, using either a
// Fibonacci or a Galois update. Includes runtime seed loading, a guard that
// keeps the register out of the all-zero state, and period detection.
//
// Parameters
//   WIDTH  state width in bits (2..32)
//   TAPS   feedback mask; default x^4+x^3+1 (maximal, period 15 at WIDTH=4)
//   SEED   reset and fallback state; must be nonzero
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   en       advance one step this cycle
//   load     load seed_in this cycle (wins over en)
//   seed_in  value loaded by load; zero is replaced with SEED
//   mode     0 = Fibonacci, 1 = Galois; sampled on every step
//   out      current state (registered)
//   bit_out  serial output, out[WIDTH-1]
//   wrap     one-cycle pulse when a step returns state to the run's start value
//   period   steps taken by the last completed run; 0 until the first wrap
//   lockup   one-cycle pulse when a zero seed load was replaced with SEED
module lfsr_gen #(
  parameter int unsigned            WIDTH = 4,
  parameter logic [WIDTH-1:0]       TAPS  = 4'b1001,
  parameter logic [WIDTH-1:0]       SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             mode,
  output logic [WIDTH-1:0] out,
  output logic             bit_out,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             lockup
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] cnt;

  logic             fib_fb;
  logic [WIDTH-1:0] fib_next;
  logic [WIDTH-1:0] gal_next;
  logic [WIDTH-1:0] next;
  logic [WIDTH-1:0] cnt_inc;

  // Both structures are computed every cycle; mode only selects, so a mode
  // change mid-run simply takes effect on the next step.
  always_comb begin
    fib_fb   = ^(state & TAPS);
    fib_next = {state[WIDTH-2:0], fib_fb};
    // Galois: shift left, fold the outgoing MSB back in through the tap mask.
    gal_next = {state[WIDTH-2:0], 1'b0} ^ ({WIDTH{state[WIDTH-1]}} & TAPS);
    next     = mode ? gal_next : fib_next;
    cnt_inc  = cnt + ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= SEED;
      start  <= SEED;
      cnt    <= '0;
      period <= '0;
      wrap   <= 1'b0;
      lockup <= 1'b0;
    end else begin
      // Pulses default low; the branches below raise them for one cycle.
      wrap   <= 1'b0;
      lockup <= 1'b0;
      if (load) begin
        // A load always restarts period measurement; period itself holds.
        cnt <= '0;
        if (seed_in != '0) begin
          state <= seed_in;
          start <= seed_in;
        end else begin
          // All-zero is the LFSR's fixed point; never let it in.
          state  <= SEED;
          start  <= SEED;
          lockup <= 1'b1;
        end
      end else if (en) begin
        state <= next;
        // Compare the incoming state so wrap lines up with out showing start.
        if (next == start) begin
          wrap   <= 1'b1;
          period <= cnt_inc;
          cnt    <= '0;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end

  assign out     = state;
  assign bit_out = state[WIDTH-1];

endmodule
